// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DMEM arbiter slice.
package dmem_arb_pkg;

    localparam int unsigned AW = 30;      // word address width (byte address bits 31:2)
    localparam int unsigned DW = 32;      // data width
    localparam int unsigned MW = DW / 8;  // byte-lane mask width

    // Port indices as stored in the latched grant
    localparam logic P_CORE = 1'b0;
    localparam logic P_DBG  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        DUMP   = 2'd3
    } state_e;

    // Request payload captured at acceptance
    typedef struct packed {
        logic          we;
        logic [MW-1:0] wmask;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response handshake bundle for one requester of the DMEM arbiter.
interface dmem_arbiter_if;
    import dmem_arb_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic          we;
    logic [MW-1:0] wmask;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    // Requester side
    modport master (
        output req_valid, we, wmask, addr, wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Arbiter side
    modport slave (
        input  req_valid, we, wmask, addr, wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester grant logic for the DMEM arbiter.
// DMEM_ARB_RR_EN defined : round-robin with a 1-bit last-grant pointer.
// DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins, no state.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt_c
);

`ifdef DMEM_ARB_RR_EN
    logic last_q;  // port granted most recently

    // Pointer update on every accepted grant; reset favours port 0
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= P_DBG;
        end else if (accept) begin
            last_q <= gnt_c[1];
        end
    end

    // On contention the port not granted last wins
    always_comb begin
        gnt_c = 2'b00;
        if (req == 2'b11) begin
            gnt_c = (last_q == P_DBG) ? 2'b01 : 2'b10;
        end else begin
            gnt_c = req;
        end
    end
`else
    logic unused_fixed;
    assign unused_fixed = &{1'b0, clk, rst, accept};

    // Port 0 always wins; port 1 may starve
    always_comb begin
        gnt_c = 2'b00;
        if (req[0]) begin
            gnt_c = 2'b01;
        end else if (req[1]) begin
            gnt_c = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 1024x32 DMEM.
// Serves one registered request at a time (accept, one access cycle, held
// response) and slots memory dumps between transactions.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration
// (fixed priority to port 0 otherwise).
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  p0,
    dmem_arbiter_if.slave  p1,
    input  logic           dump_req,
    output logic           dump_done,
    output logic           mem_we,
    output logic [MW-1:0]  mem_wmask,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata,
    output logic           mem_dump
);

    state_e        state_q;
    state_e        state_d;
    logic          dump_pend_q;
    logic          dump_pend_d;
    logic          port_q;
    req_t          req_q;
    req_t          req_sel;
    logic [DW-1:0] rdata_q;
    logic [1:0]    arb_req;
    logic [1:0]    gnt_c;
    logic          accept_c;
    logic          rsp_ready_sel;

    // Requests are only eligible in IDLE with no dump waiting
    assign arb_req  = {p1.req_valid, p0.req_valid} & {2{(state_q == IDLE) && !dump_pend_q}};
    assign accept_c = |gnt_c;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .accept (accept_c),
        .gnt_c  (gnt_c)
    );

    assign p0.req_ready = gnt_c[0];
    assign p1.req_ready = gnt_c[1];

    // Payload of the winning port
    always_comb begin
        req_sel = '0;
        if (gnt_c[1]) begin
            req_sel.we    = p1.we;
            req_sel.wmask = p1.wmask;
            req_sel.addr  = p1.addr;
            req_sel.wdata = p1.wdata;
        end else begin
            req_sel.we    = p0.we;
            req_sel.wmask = p0.wmask;
            req_sel.addr  = p0.addr;
            req_sel.wdata = p0.wdata;
        end
    end

    assign rsp_ready_sel = (port_q == P_DBG) ? p1.rsp_ready : p0.rsp_ready;

    // Next-state and dump-pending logic; dump beats requests in IDLE
    always_comb begin
        state_d     = state_q;
        dump_pend_d = dump_pend_q | dump_req;
        unique case (state_q)
            IDLE: begin
                if (dump_pend_q) begin
                    state_d     = DUMP;
                    dump_pend_d = 1'b0;
                end else if (accept_c) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_sel) begin
                    state_d = IDLE;
                end
            end
            DUMP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pending-dump flag and dump completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dump_pend_q <= 1'b0;
            dump_done   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dump_pend_q <= dump_pend_d;
            dump_done   <= (state_q == DUMP);
        end
    end

    // Capture the granted request and its port
    always_ff @(posedge clk) begin
        if (rst) begin
            port_q <= P_CORE;
            req_q  <= '0;
        end else if (accept_c) begin
            port_q <= gnt_c[1];
            req_q  <= req_sel;
        end
    end

    // Response register: read data for loads, zero for stores
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state_q == ACCESS) begin
            rdata_q <= req_q.we ? '0 : mem_rdata;
        end
    end

    // DMEM is driven only during ACCESS; decoded from state so a write
    // in its ACCESS cycle commits even if reset lands on that edge
    always_comb begin
        mem_we    = 1'b0;
        mem_wmask = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ACCESS) begin
            mem_we    = req_q.we;
            mem_wmask = req_q.wmask;
            mem_addr  = req_q.addr;
            mem_wdata = req_q.wdata;
        end
    end

    assign mem_dump = (state_q == DUMP);

    // Held response towards the granted port only
    assign p0.rsp_valid = (state_q == RESP) && (port_q == P_CORE);
    assign p1.rsp_valid = (state_q == RESP) && (port_q == P_DBG);
    assign p0.rsp_rdata = p0.rsp_valid ? rdata_q : '0;
    assign p1.rsp_rdata = p1.rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random transactions
// checked against a transaction-level memory/grant model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          dump_req;
    logic          dump_done;
    logic          mem_we;
    logic [MW-1:0] mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_dump;

    dmem_arbiter_if p0_bus ();
    dmem_arbiter_if p1_bus ();

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .p0        (p0_bus),
        .p1        (p1_bus),
        .dump_req  (dump_req),
        .dump_done (dump_done),
        .mem_we    (mem_we),
        .mem_wmask (mem_wmask),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_dump  (mem_dump)
    );

    always #5 clk = ~clk;

    // DMEM: combinational read, byte-lane write, low 10 address bits decoded
    logic [DW-1:0] dmem [1024];
    assign mem_rdata = dmem[mem_addr[9:0]];

    initial begin
        for (int i = 0; i < 1024; i++) dmem[i] <= '0;
        dmem[25] <= 32'h8475_5779;
    end

    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) dmem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [1024];
    logic        last_gnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ref_write(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) ref_mem[a[9:0]][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic drive(input logic p, input logic v, input logic we, input logic [3:0] m,
                         input logic [29:0] a, input logic [31:0] d);
        if (p) begin
            p1_bus.req_valid = v; p1_bus.we = we; p1_bus.wmask = m; p1_bus.addr = a; p1_bus.wdata = d;
        end else begin
            p0_bus.req_valid = v; p0_bus.we = we; p0_bus.wmask = m; p0_bus.addr = a; p0_bus.wdata = d;
        end
    endtask

    task automatic set_rsp_ready(input logic p, input logic v);
        if (p) p1_bus.rsp_ready = v;
        else   p0_bus.rsp_ready = v;
    endtask

    function automatic logic rdy_of(input logic p);
        return p ? p1_bus.req_ready : p0_bus.req_ready;
    endfunction

    function automatic logic rv_of(input logic p);
        return p ? p1_bus.rsp_valid : p0_bus.rsp_valid;
    endfunction

    function automatic logic [31:0] rd_of(input logic p);
        return p ? p1_bus.rsp_rdata : p0_bus.rsp_rdata;
    endfunction

    // One complete transaction on port p; called and returns just after a falling edge
    task automatic txn(input logic p, input logic we, input logic [3:0] m, input logic [29:0] a,
                       input logic [31:0] d, input int stall, input logic hold_other,
                       input logic dump_in_stall);
        logic [31:0] exp_rd;
        logic        rdy;
        int          k;
        drive(p, 1'b1, we, m, a, d);
        #1;
        rdy = rdy_of(p);
        k = 0;
        while (!rdy && k < 40) begin
            @(negedge clk); #1;
            rdy = rdy_of(p);
            k++;
        end
        chk("accept", 32'(rdy), 32'd1);
        if (!rdy) begin
            drive(p, 1'b0, we, m, a, d);
            @(negedge clk);
            return;
        end
        chk("idle_mem_we", 32'(mem_we), 32'd0);
        exp_rd = we ? 32'd0 : ref_mem[a[9:0]];
        if (we) ref_write(a, m, d);
        last_gnt = p;

        @(negedge clk);
        drive(p, 1'b0, we, m, a, d);
        if (hold_other) drive(~p, 1'b1, 1'b0, 4'hF, 30'd0, 32'd0);
        chk("acc_we",    32'(mem_we),    32'(we));
        chk("acc_addr",  32'(mem_addr),  32'(a));
        chk("acc_wmask", 32'(mem_wmask), 32'(m));
        chk("acc_wdata", mem_wdata,      d);
        chk("acc_no_rsp", 32'(rv_of(p)), 32'd0);

        @(negedge clk);
        chk("rsp_valid",      32'(rv_of(p)),  32'd1);
        chk("rsp_rdata",      rd_of(p),       exp_rd);
        chk("other_rsp_idle", 32'(rv_of(~p)), 32'd0);

        for (int s = 0; s < stall; s++) begin
            if (dump_in_stall && s == 0) dump_req = 1'b1;
            @(negedge clk);
            dump_req = 1'b0;
            chk("stall_valid",       32'(rv_of(p)),   32'd1);
            chk("stall_rdata",       rd_of(p),        exp_rd);
            chk("stall_other_ready", 32'(rdy_of(~p)), 32'd0);
        end

        set_rsp_ready(p, 1'b1);
        @(negedge clk);
        set_rsp_ready(p, 1'b0);
        chk("rsp_released", 32'(rv_of(p)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       r0;
        logic       r1;
        logic       exp_g;
        int         cnt;
        logic       rp;
        logic       rwe;
        logic [3:0] rm;
        logic [29:0] ra;

        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        ref_mem[25] = 32'h8475_5779;
        rst      = 1'b1;
        dump_req = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 30'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 30'd0, 32'd0);
        set_rsp_ready(1'b0, 1'b0);
        set_rsp_ready(1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_mem_we",    32'(mem_we),           32'd0);
        chk("rst_mem_addr",  32'(mem_addr),         32'd0);
        chk("rst_mem_dump",  32'(mem_dump),         32'd0);
        chk("rst_dump_done", 32'(dump_done),        32'd0);
        chk("rst_p0_rsp",    32'(p0_bus.rsp_valid), 32'd0);
        chk("rst_p1_rsp",    32'(p1_bus.rsp_valid), 32'd0);
        chk("rst_state",     32'(dut.state_q),      32'(IDLE));
        rst      = 1'b0;
        last_gnt = P_DBG;
        @(negedge clk);

        // Basic write/read, zero-mask write, aliased high address bits
        txn(1'b0, 1'b1, 4'hF, 30'd5, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 4'hF, 30'd5, 32'h0,         0, 1'b0, 1'b0);
        txn(1'b0, 1'b1, 4'h0, 30'd5, 32'h1111_1111, 0, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 4'hF, 30'd5, 32'h0,         1, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 4'hF, {20'hABCDE, 10'd5}, 32'h0, 0, 1'b0, 1'b0);

        // Port-1 partial write over preset word
        txn(1'b1, 1'b1, 4'h5, 30'd25, 32'hAABB_CCDD, 0, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 4'hF, 30'd25, 32'h0,         0, 1'b0, 1'b0);

        // Both ports valid every cycle: grant order
        drive(1'b0, 1'b1, 1'b0, 4'hF, 30'd10, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 4'hF, 30'd11, 32'd0);
        set_rsp_ready(1'b0, 1'b1);
        set_rsp_ready(1'b1, 1'b1);
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            #1;
            r0 = p0_bus.req_ready;
            r1 = p1_bus.req_ready;
            chk("ready_onehot", 32'(r0 & r1), 32'd0);
            if (r0 | r1) begin
                if (cnt == 6) begin
                    drive(1'b0, 1'b0, 1'b0, 4'hF, 30'd10, 32'd0);
                    drive(1'b1, 1'b0, 1'b0, 4'hF, 30'd11, 32'd0);
                    break;
                end
`ifdef DMEM_ARB_RR_EN
                exp_g = ~last_gnt;
`else
                exp_g = P_CORE;
`endif
                chk("grant_order", 32'(r1), 32'(exp_g));
                last_gnt = r1;
                cnt++;
            end
            @(negedge clk);
        end
        chk("grant_count", 32'(cnt), 32'd6);
        drive(1'b0, 1'b0, 1'b0, 4'hF, 30'd10, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 4'hF, 30'd11, 32'd0);
        set_rsp_ready(1'b0, 1'b0);
        set_rsp_ready(1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Response stall with port 1 waiting
        txn(1'b0, 1'b0, 4'hF, 30'd25, 32'h0, 4, 1'b1, 1'b0);
        txn(1'b1, 1'b0, 4'hF, 30'd5,  32'h0, 0, 1'b0, 1'b0);

        // Dump requested during a stall goes ahead of the waiting request
        txn(1'b0, 1'b0, 4'hF, 30'd25, 32'h0, 4, 1'b1, 1'b1);
        chk("dump_blocks_req", 32'(rdy_of(1'b1)), 32'd0);
        chk("dump_not_yet",    32'(mem_dump),     32'd0);
        @(negedge clk);
        chk("dump_strobe",     32'(mem_dump),     32'd1);
        chk("dump_done_early", 32'(dump_done),    32'd0);
        chk("dump_req_held",   32'(rdy_of(1'b1)), 32'd0);
        @(negedge clk);
        chk("dump_single",     32'(mem_dump),     32'd0);
        chk("dump_done",       32'(dump_done),    32'd1);
        txn(1'b1, 1'b0, 4'hF, 30'd25, 32'h0, 0, 1'b0, 1'b0);
        chk("dump_done_pulse", 32'(dump_done),    32'd0);

        // Reset landing on the ACCESS cycle of a write
        drive(1'b0, 1'b1, 1'b1, 4'hF, 30'd3, 32'h1234_5678);
        #1;
        chk("rst_case_accept", 32'(p0_bus.req_ready), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 4'hF, 30'd3, 32'h1234_5678);
        chk("rst_case_access", 32'(mem_we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_write(30'd3, 4'hF, 32'h1234_5678);
        last_gnt = P_DBG;
        chk("rst_case_state",  32'(dut.state_q),      32'(IDLE));
        chk("rst_case_no_rsp", 32'(p0_bus.rsp_valid), 32'd0);
        chk("rst_case_mem_we", 32'(mem_we),           32'd0);
        @(negedge clk);
        chk("rst_case_no_rsp2", 32'(p0_bus.rsp_valid), 32'd0);
        txn(1'b0, 1'b0, 4'hF, 30'd3, 32'h0, 0, 1'b0, 1'b0);

        // Random single-port traffic against the memory model
        for (int i = 0; i < 60; i++) begin
            rp  = 1'($urandom_range(0, 1));
            rwe = 1'($urandom_range(0, 1));
            rm  = 4'($urandom);
            ra  = {20'($urandom), 10'($urandom_range(0, 15))};
            txn(rp, rwe, rm, ra, $urandom, int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
